// File: rtl/data_mem.sv
// data_mem: data memory for the single-cycle MIPS datapath.
// The ALU result is the byte address. Loads are combinational and complete
// in their own cycle. Stores commit on the rising clock edge. Misaligned,
// out-of-range and reserved-size accesses are suppressed and reported on
// 'fault'. A sticky error register holds the first fault until cleared.
//
// Handshake: there is no valid/ready pair. mem_re/mem_we qualify the access
// in the current cycle. rdata and fault are valid combinationally in that
// same cycle. The store and the error capture take effect at the next
// rising edge of clk.
module data_mem #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic        err_clr,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        err_sticky,
  output logic [31:0] err_addr,
  output logic [1:0]  err_cause
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] SIZE_B    = 2'b00;
  localparam logic [1:0] SIZE_H    = 2'b01;
  localparam logic [1:0] SIZE_W    = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;
  localparam logic [1:0] CAUSE_SIZE     = 2'b11;

  // Storage, one 32-bit word per entry, little-endian lanes.
  logic [31:0] mem_q [DEPTH];

  // Address decode and fault classification.
  logic [31:0]           off;
  logic                  in_range;
  logic                  misaligned;
  logic                  rsvd_size;
  logic                  access;
  logic [DEPTH_LOG2-1:0] word_idx;
  logic [1:0]            lane;
  logic [1:0]            cause;

  // Read path and write merge.
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rdata_d;
  logic        wr_en;
  logic [31:0] wr_word_d;

  // Sticky error state.
  logic        err_sticky_q, err_sticky_d;
  logic [31:0] err_addr_q,   err_addr_d;
  logic [1:0]  err_cause_q,  err_cause_d;

  // Decode the offset from the base; an address below the base wraps to a
  // large offset and so lands out of range instead of aliasing.
  always_comb begin
    off        = addr - BASE_ADDR;
    in_range   = (off >> (DEPTH_LOG2 + 2)) == 32'd0;
    word_idx   = off[DEPTH_LOG2+1:2];
    lane       = off[1:0];
    rsvd_size  = (mem_size == SIZE_RSVD);
    access     = mem_we | mem_re;
    misaligned = 1'b0;
    case (mem_size)
      SIZE_H:  misaligned = off[0];
      SIZE_W:  misaligned = |off[1:0];
      default: misaligned = 1'b0;
    endcase
    fault = access & (~in_range | misaligned | rsvd_size);
  end

  // Cause code with priority reserved size > out of range > misaligned.
  always_comb begin
    cause = CAUSE_NONE;
    if (rsvd_size) begin
      cause = CAUSE_SIZE;
    end else if (!in_range) begin
      cause = CAUSE_RANGE;
    end else if (misaligned) begin
      cause = CAUSE_MISALIGN;
    end
  end

  // Combinational load: lane select then sign/zero extension. This reads
  // the pre-edge contents, which gives read-during-write its old-data view.
  always_comb begin
    rd_word = mem_q[word_idx];
    rd_byte = rd_word[{lane, 3'b000} +: 8];
    rd_half = rd_word[{lane[1], 4'b0000} +: 16];
    rdata_d = 32'd0;
    case (mem_size)
      SIZE_B:  rdata_d = {{24{~mem_unsigned & rd_byte[7]}}, rd_byte};
      SIZE_H:  rdata_d = {{16{~mem_unsigned & rd_half[15]}}, rd_half};
      SIZE_W:  rdata_d = rd_word;
      default: rdata_d = 32'd0;
    endcase
    rdata = (mem_re && !fault) ? rdata_d : 32'd0;
  end

  // Store merge: replace only the addressed lane(s) of the current word.
  always_comb begin
    wr_en     = mem_we & ~fault;
    wr_word_d = rd_word;
    case (mem_size)
      SIZE_B:  wr_word_d[{lane, 3'b000} +: 8]     = wdata[7:0];
      SIZE_H:  wr_word_d[{lane[1], 4'b0000} +: 16] = wdata[15:0];
      SIZE_W:  wr_word_d = wdata;
      default: wr_word_d = rd_word;
    endcase
  end

  // Memory array: cleared immediately by reset, one word written per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else if (wr_en) begin
      mem_q[word_idx] <= wr_word_d;
    end
  end

  // Next sticky state: clear wins, otherwise capture only the first fault.
  always_comb begin
    err_sticky_d = err_sticky_q;
    err_addr_d   = err_addr_q;
    err_cause_d  = err_cause_q;
    if (err_clr) begin
      err_sticky_d = 1'b0;
      err_addr_d   = 32'd0;
      err_cause_d  = CAUSE_NONE;
    end else if (fault && !err_sticky_q) begin
      err_sticky_d = 1'b1;
      err_addr_d   = addr;
      err_cause_d  = cause;
    end
  end

  // Sticky error register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_q <= 1'b0;
      err_addr_q   <= 32'd0;
      err_cause_q  <= CAUSE_NONE;
    end else begin
      err_sticky_q <= err_sticky_d;
      err_addr_q   <= err_addr_d;
      err_cause_q  <= err_cause_d;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_addr   = err_addr_q;
  assign err_cause  = err_cause_q;

endmodule

// File: tb/tb_data_mem.sv
// Bench for data_mem: directed cases from the bring-up list followed by
// random traffic, checked against a byte-addressed reference memory.
`timescale 1ns/1ps
module tb_data_mem;

  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          MEM_BYTES = 4096;

  // Clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0] addr, wdata, rdata, err_addr;
  logic        mem_we, mem_re, mem_unsigned, err_clr, fault, err_sticky;
  logic [1:0]  mem_size, err_cause;

  data_mem #(.DEPTH_LOG2(10), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_size(mem_size),
    .mem_unsigned(mem_unsigned), .err_clr(err_clr),
    .rdata(rdata), .fault(fault), .err_sticky(err_sticky),
    .err_addr(err_addr), .err_cause(err_cause)
  );

  typedef struct packed {
    logic [31:0] rdata;
    logic        fault;
    logic        sticky;
    logic [31:0] eaddr;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic drv_valid = 1'b0;

  // Reference model: plain byte array plus the error record.
  logic [7:0]  ref_mem [MEM_BYTES];
  logic        ref_sticky;
  logic [31:0] ref_eaddr;
  logic [1:0]  ref_cause;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h00;
    ref_sticky = 1'b0;
    ref_eaddr  = 32'd0;
    ref_cause  = 2'b00;
  endtask

  // Computes the response to one access, then advances the model as the
  // coming clock edge would.
  task automatic model_step(input logic we, input logic re, input logic [1:0] size,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            input logic clr, output exp_t e);
    logic [31:0] off, v;
    int          nb;
    bit          inr, mis, flt;
    off = a - BASE;
    inr = off < 32'(MEM_BYTES);
    nb  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis = (size != 2'd3) && ((off % 32'(nb)) != 32'd0);
    flt = (we || re) && ((size == 2'd3) || !inr || mis);
    e.rdata = 32'd0;
    if (re && !flt) begin
      v = 32'd0;
      for (int k = 0; k < nb; k++) v = v | (32'(ref_mem[int'(off) + k]) << (8 * k));
      if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'h1 << (8 * nb)) - 32'h1);
      e.rdata = v;
    end
    e.fault  = flt;
    e.sticky = ref_sticky;
    e.eaddr  = ref_eaddr;
    e.cause  = ref_cause;
    if (we && !flt) begin
      for (int k = 0; k < nb; k++) ref_mem[int'(off) + k] = wd[8*k +: 8];
    end
    if (clr) begin
      ref_sticky = 1'b0;
      ref_eaddr  = 32'd0;
      ref_cause  = 2'b00;
    end else if (flt && !ref_sticky) begin
      ref_sticky = 1'b1;
      ref_eaddr  = a;
      ref_cause  = (size == 2'd3) ? 2'b11 : !inr ? 2'b10 : 2'b01;
    end
  endtask

  task automatic set_idle();
    mem_we = 1'b0; mem_re = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
    addr = 32'd0; wdata = 32'd0; err_clr = 1'b0;
  endtask

  // Driver: one access per cycle, applied just after the rising edge.
  task automatic do_cycle(input logic we, input logic re, input logic [1:0] size,
                          input logic uns, input logic [31:0] a, input logic [31:0] wd,
                          input logic clr);
    exp_t e;
    @(posedge clk);
    #1;
    mem_we = we; mem_re = re; mem_size = size; mem_unsigned = uns;
    addr = a; wdata = wd; err_clr = clr;
    model_step(we, re, size, uns, a, wd, clr, e);
    exp_q.push_back(e);
    drv_valid = 1'b1;
  endtask

  task automatic idle_cycle();
    do_cycle(1'b0, 1'b0, 2'b10, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  // Monitor: compares the presented outputs against the oldest expectation.
  always @(negedge clk) begin
    if (drv_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow actual=empty expected=entry (t=%0t)", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("rdata",      rdata,            mon_e.rdata);
        check("fault",      32'(fault),       32'(mon_e.fault));
        check("err_sticky", 32'(err_sticky),  32'(mon_e.sticky));
        check("err_addr",   err_addr,         mon_e.eaddr);
        check("err_cause",  32'(err_cause),   32'(mon_e.cause));
      end
    end
  end

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // Watchdog
  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog actual=timeout expected=finish");
    report();
    $finish;
  end

  // Stimulus
  initial begin
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    int          sel;
    rst_n = 1'b1;
    set_idle();
    model_reset();
    #1 rst_n = 1'b0;
    mem_re = 1'b1; addr = 32'h10;
    #2;
    check("reset_rdata",      rdata,           32'd0);
    check("reset_err_sticky", 32'(err_sticky), 32'd0);
    check("reset_err_addr",   err_addr,        32'd0);
    check("reset_err_cause",  32'(err_cause),  32'd0);
    set_idle();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // 1: word store/load
    do_cycle(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0);
    do_cycle(0, 1, 2'b10, 0, 32'h10, 32'h0, 0);
    // 2: byte and halfword lanes
    do_cycle(1, 0, 2'b00, 0, 32'h11, 32'h0000_0080, 0);
    do_cycle(0, 1, 2'b00, 0, 32'h11, 32'h0, 0);
    do_cycle(0, 1, 2'b00, 1, 32'h11, 32'h0, 0);
    do_cycle(0, 1, 2'b10, 0, 32'h10, 32'h0, 0);
    do_cycle(0, 1, 2'b01, 0, 32'h12, 32'h0, 0);
    do_cycle(0, 1, 2'b01, 1, 32'h12, 32'h0, 0);
    // 3: misaligned load, then misaligned store while sticky is held
    do_cycle(0, 1, 2'b10, 0, 32'h22, 32'h0, 0);
    do_cycle(1, 0, 2'b01, 0, 32'h23, 32'h0000_5A5A, 0);
    do_cycle(0, 1, 2'b10, 0, 32'h20, 32'h0, 0);
    // 4: out of range store must neither write nor alias onto word 0
    do_cycle(0, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    do_cycle(1, 0, 2'b10, 0, 32'h0, 32'h0BADF00D, 0);
    do_cycle(1, 0, 2'b10, 0, 32'h1000, 32'hCAFEF00D, 0);
    do_cycle(0, 1, 2'b10, 0, 32'h0, 32'h0, 0);
    do_cycle(0, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    idle_cycle();
    // reserved size and below-base wrap
    do_cycle(0, 1, 2'b11, 0, 32'h4, 32'h0, 0);
    do_cycle(0, 1, 2'b00, 0, 32'hFFFF_FFFC, 32'h0, 1);
    do_cycle(0, 1, 2'b00, 0, 32'hFFFF_FFFC, 32'h0, 0);
    do_cycle(0, 0, 2'b10, 0, 32'h0, 32'h0, 1);
    // 5: read-during-write returns old data, new data next cycle
    do_cycle(1, 1, 2'b10, 0, 32'h40, 32'h12345678, 0);
    do_cycle(0, 1, 2'b10, 0, 32'h40, 32'h0, 0);
    do_cycle(0, 1, 2'b10, 0, 32'h22, 32'h0, 0);

    // 6: reset between edges with a store in flight
    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    mem_we = 1'b1; mem_re = 1'b1; mem_size = 2'b10; mem_unsigned = 1'b0;
    addr = 32'h40; wdata = 32'hAAAA5555; err_clr = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_async_rdata",      rdata,           32'd0);
    check("rst_async_err_sticky", 32'(err_sticky), 32'd0);
    check("rst_async_err_addr",   err_addr,        32'd0);
    mem_we = 1'b0;
    @(posedge clk);
    #1;
    check("rst_held_rdata", rdata, 32'd0);
    set_idle();
    @(negedge clk) rst_n = 1'b1;
    do_cycle(0, 1, 2'b10, 0, 32'h40, 32'h0, 0);
    idle_cycle();

    // Random traffic concentrated on a few regions so accesses collide.
    for (int i = 0; i < 400; i++) begin
      sel = $urandom_range(0, 9);
      if (sel < 7)      r_addr = 32'($urandom_range(0, 127));
      else if (sel < 9) r_addr = 32'h0FF0 + 32'($urandom_range(0, 31));
      else              r_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      r_size = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r_size,
               1'($urandom_range(0, 1)), r_addr, $urandom(),
               1'($urandom_range(0, 19) == 0));
    end

    @(posedge clk);
    #1;
    drv_valid = 1'b0;
    set_idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    report();
    $finish;
  end

endmodule

// File: doc/data_mem.md
Name: data_mem

Overview:
- Data memory stage directly downstream of the ALU in the single-cycle MIPS datapath.
- The ALU result is used as the byte address for lw/lh/lhu/lb/lbu/sw/sh/sb.
- Reads are combinational so a load completes in its own cycle. Writes commit on the rising clock edge.
- Misaligned and out-of-range accesses are suppressed and flagged. A sticky error register captures the first fault for the control/exception path.

Parameters:
- DEPTH_LOG2, 10, log2 of word count (1024 x 32-bit words = 4 KiB).
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4 KiB aligned for the default depth.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  32  byte address, driven by the ALU result.
- wdata  input  32  store data (rt register value).
- mem_we  input  1  store enable.
- mem_re  input  1  load enable.
- mem_size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
- mem_unsigned  input  1  loads: 1 zero-extends, 0 sign-extends; ignored for word.
- err_clr  input  1  synchronous clear of the sticky error state.
- rdata  output  32  load result, already extended.
- fault  output  1  combinational: current access is faulting.
- err_sticky  output  1  registered: a fault has occurred since reset/clear.
- err_addr  output  32  registered: address of the first fault.
- err_cause  output  2  registered: 01 misaligned, 10 out of range, 11 reserved size.

Behaviour:
- Address decoding:
  - off = addr - BASE_ADDR.
  - in_range when off[31:DEPTH_LOG2+2] == 0.
  - Word index = off[DEPTH_LOG2+1:2].
  - Lane = off[1:0].
- Byte ordering is little-endian:
  - Byte lane k = word[8k+7:8k].
  - Halfword lane 0 = [15:0], lane 2 = [31:16].
- Alignment rules:
  - Halfword requires off[0]==0.
  - Word requires off[1:0]==0.
  - Byte is always aligned.
- Fault definition:
  - fault = (mem_we|mem_re) & (!in_range | misaligned | mem_size==11).
  - Cause priority when several apply: reserved size > out-of-range > misaligned.
- Reads (combinational, zero latency):
  - mem_re=1 with no fault: select the addressed lane, then sign- or zero-extend per mem_unsigned and mem_size.
  - mem_re=0 or fault: rdata = 0.
- Writes, at the rising clk edge when mem_we=1 and no fault:
  - Byte: wdata[7:0] goes into the addressed lane; the other lanes are untouched.
  - Halfword: wdata[15:0] goes into the addressed half.
  - Word: the full word is written.
- Faulting store: memory is unchanged.
- Read-during-write, same cycle and same word: rdata shows the pre-edge contents. The new value is visible in the next cycle.
- mem_we and mem_re both 1: legal. Both the read and the write happen, with the read-during-write rule above.
- Sticky error register, updated on the rising clk edge:
  - err_clr=1: err_sticky, err_addr and err_cause go to 0. Clear has priority over capture in the same cycle.
  - Otherwise, fault=1 and err_sticky=0: err_sticky goes to 1, err_addr to addr, err_cause to the cause code.
  - Later faults while err_sticky=1 do not overwrite the captured values.
- Asynchronous reset (rst_n=0), taking effect immediately and independent of clk:
  - All memory words = 0.
  - err_sticky = 0, err_addr = 0, err_cause = 0.
  - rdata reads 0 for any address during and after reset.
  - A store in flight when reset asserts is discarded.
- No write takes effect while rst_n=0. The first write can occur at the first rising edge after rst_n deasserts.
- Address wrap-around:
  - An addr below BASE_ADDR wraps in the subtraction and is flagged out of range.
  - There is no modulo aliasing.

Test Plan:
1. Word store/load: sw 32'hDEADBEEF at 0x10, then lw 0x10 the next cycle -> rdata=DEADBEEF, fault=0.
2. Byte/half lanes: after test 1:
   - sb 8'h80 at 0x11, then lb 0x11 -> FFFFFF80; lbu 0x11 -> 00000080; lw 0x10 -> DEAD80EF.
   - lh 0x12 -> FFFFDEAD; lhu 0x12 -> 0000DEAD.
3. Misaligned accesses:
   - lw 0x22 -> rdata=0, fault=1; err_sticky=1, err_addr=0x22, err_cause=01 at the next edge.
   - A following sh 0x23 leaves memory unchanged and err_addr stays 0x22.
4. Out of range: sw at 0x1000 with default depth -> fault=1, err_cause=10, no write; lw 0x0 still returns its prior value. err_clr pulse -> sticky state cleared next edge.
5. Read-during-write: sw 32'h12345678 to 0x40 (previously 0) with mem_re=1 same cycle -> rdata=0 that cycle, 12345678 the next cycle.
6. Reset mid-operation: write 0x40, assert rst_n low between edges -> rdata=0 immediately; after release lw 0x40 -> 0 and err_sticky=0.
